// File: rtl/adder_stream_unit.sv
// -----------------------------------------------------------------------------
// adder_stream_unit
//
// Purpose:
//   Accepts operand pairs over a valid/ready handshake and registers them in a
//   single stage-1 register. On the following edge, the WIDTH-bit sum, the
//   carry-out and the signed overflow flag are pushed into a DEPTH-entry result
//   FIFO. Results are returned in acceptance order through a valid/ready
//   output. The FIFO absorbs consumer back-pressure.
//
// Handshake semantics (both ports):
//   A transfer happens on a posedge where valid && ready are both high. Once a
//   producer raises valid, it keeps valid and its data stable until that
//   transfer happens. Ready may rise or fall freely. On the output side, the
//   unit never drops out_valid and never changes the head result without a
//   pop. On the input side, in_ready depends only on registered state.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   reset      synchronous, active-high
//   in_valid   operand pair present on in_a/in_b
//   in_ready   unit can accept an operand pair this cycle
//   in_a/in_b  unsigned operands, WIDTH bits
//   out_valid  result at FIFO head is available
//   out_ready  consumer takes the head result this cycle
//   out_sum    (in_a + in_b) mod 2^WIDTH of the head entry
//   out_carry  carry-out of the head entry
//   out_ovf    signed overflow flag of the head entry
//   count      number of results held in the FIFO
// -----------------------------------------------------------------------------
module adder_stream_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_carry,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 2;   // {ovf, carry, sum}

    // Stage-1 operand register
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Result FIFO
    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_add;
    logic             w_ovf;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_occupancy;
    logic [EW-1:0]    w_head;

    // Adder on the stage-1 operands. Overflow: operands share a sign bit and
    // the sum's sign bit differs from it.
    assign w_add = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                   (w_add[WIDTH-1] != r_s1_a[WIDTH-1]);

    // Credit: results already buffered plus the one in stage 1 must leave a
    // free slot. Because of this, the stage-1 push can never find the FIFO
    // full, and push needs no stall path.
    assign w_occupancy = r_count + CW'(r_s1_valid);
    assign in_ready    = (w_occupancy < CW'(DEPTH));

    assign w_accept    = in_valid && in_ready;
    assign w_push      = r_s1_valid;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && out_ready;

    // Head outputs are forced to zero while empty. Stale storage is therefore
    // never visible after reset.
    assign w_head      = r_mem[r_rd_ptr];
    assign out_sum     = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_carry   = out_valid ? w_head[WIDTH]     : 1'b0;
    assign out_ovf     = out_valid ? w_head[WIDTH+1]   : 1'b0;
    assign count       = r_count;

    // Stage 1: a new accept reloads the register. Otherwise the valid flag
    // clears on the edge where the previous pair is pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a <= in_a;
                r_s1_b <= in_b;
            end
        end
    end

    // FIFO storage is not reset. Only the pointers and count define its
    // contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_ovf, w_add};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_stream_unit.sv
// -----------------------------------------------------------------------------
// tb_adder_stream_unit
//
// Drives directed and random operand traffic into adder_stream_unit. Every
// cycle, a queue-based reference model is compared against in_ready,
// out_valid, count and the head result. The model records each accepted pair
// together with the edge index at which it was taken. A result becomes visible
// one edge after its accept. A result leaves the model on a pop by the
// consumer.
// -----------------------------------------------------------------------------
module tb_adder_stream_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (WIDTH - 1));

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic [CW-1:0]    count;

    int passed = 0;
    int total  = 0;
    int edge_n = 0;
    bit last_acc;

    logic [WIDTH+1:0] exp_q[$];   // expected {ovf, carry, sum}, acceptance order
    int               acc_q[$];   // edge index at which each entry was accepted

    adder_stream_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .count     (count)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    // ---------------- reference model ----------------
    // Overflow is the signed sum falling outside the representable range.
    function automatic logic [WIDTH+1:0] ref_result(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        longint         sa;
        longint         sb;
        longint         ss;
        logic [WIDTH:0] full;
        logic           ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ss   = sa + sb;
        ovf  = (ss > SMAX) || (ss < SMIN);
        full = {1'b0, a} + {1'b0, b};
        return {ovf, full};
    endfunction

    // Entries whose push edge (accept edge + 1) has already happened.
    function automatic int visible_count();
        int n;
        n = 0;
        for (int i = 0; i < acc_q.size(); i++) begin
            if (acc_q[i] + 1 <= edge_n) n++;
            else break;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver ----------------
    // Call this with the inputs already set. The task decides from the model
    // whether an accept and/or a pop happens on the coming edge, advances one
    // edge, and checks the visible state.
    task automatic tick();
        bit acc;
        bit pop;
        int n;
        acc = in_valid && (exp_q.size() < DEPTH);
        pop = out_ready && (visible_count() > 0);
        if (pop) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(ref_result(in_a, in_b));
            acc_q.push_back(edge_n + 1);
        end
        last_acc = acc;
        @(posedge clk);
        edge_n++;
        #1;
        n = visible_count();
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
        check("count", 64'(count), 64'(n));
        check("out_valid", 64'(out_valid), 64'(n != 0));
        if (n != 0) check("head", 64'({out_ovf, out_carry, out_sum}), 64'(exp_q[0]));
        else        check("head_zero", 64'({out_ovf, out_carry, out_sum}), 64'(0));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        edge_n++;
        #1;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_head", 64'({out_ovf, out_carry, out_sum}), 64'(0));
    endtask

    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        last_acc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) break;
        end
        check("send_timeout", 64'(last_acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int idx;
        int acc_cnt;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;

        do_reset();

        // Single pair and latency
        out_ready = 1'b1;
        send_pair(32'h0000_0005, 32'h0000_0003);
        tick();
        check("lat_out_valid", 64'(out_valid), 64'(1));
        check("sum_5_3", 64'({out_ovf, out_carry, out_sum}), 64'h0_0000_0008);
        tick();
        tick();
        check("count_back_0", 64'(count), 64'(0));

        // Carry and signed overflow corners
        send_pair(32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        check("carry_case", 64'({out_ovf, out_carry, out_sum}), 64'h1_0000_0000);
        send_pair(32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        check("ovf_case", 64'({out_ovf, out_carry, out_sum}), 64'h2_8000_0000);
        drain();

        // Back-pressure: six pairs i+i with out_ready low
        out_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'(idx);
            in_b     = WIDTH'(idx);
            tick();
            if (last_acc) idx++;
        end
        check("bp_accepted", 64'(idx - 1), 64'(4));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_count", 64'(count), 64'(4));
        check("bp_head", 64'(out_sum), 64'(2));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_head_stable", 64'(out_sum), 64'(2));
        end
        out_ready = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (idx > 6) break;
            in_valid = 1'b1;
            in_a     = WIDTH'(idx);
            in_b     = WIDTH'(idx);
            tick();
            if (last_acc) idx++;
        end
        check("bp_all_accepted", 64'(idx - 1), 64'(6));
        drain();

        // Push and pop on the same edge near full, then stream so the pointers wrap
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) send_pair($urandom, $urandom);
        check("pp_count_before", 64'(count), 64'(3));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        tick();
        check("pp_count_same", 64'(count), 64'(3));
        for (int c = 0; c < 6; c++) send_pair($urandom, $urandom);
        drain();

        // Reset one cycle after accepting 9+9 with three results queued
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) send_pair(WIDTH'(20 + c), WIDTH'(c));
        tick();
        check("mid_count3", 64'(count), 64'(3));
        send_pair(32'd9, 32'd9);
        do_reset();
        out_ready = 1'b1;
        send_pair(32'd1, 32'd2);
        tick();
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_first", 64'(out_sum), 64'(3));
        drain();

        // Random traffic with 50% consumer back-pressure
        acc_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (acc_cnt >= 100) break;
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            in_b      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_acc) acc_cnt++;
        end
        check("rand_accepted", 64'(acc_cnt), 64'(100));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
